// File: rtl/mux_scan_sampler.sv
// Scan sequencer around a 4:1 mux: steps the select through channels 0..3,
// samples each after a settle dwell and hands the 4-bit word off on valid/ready.
module mux_scan_sampler #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CONT,
  output logic [1:0] SL,
  input  logic       MUX_OUT,
  output logic [3:0] WORD,
  output logic       VALID,
  input  logic       READY,
  output logic       CHG,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [1:0] sl_q, sl_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] stage_q, stage_d;
  logic [3:0] word_q, word_d;
  logic       valid_q, valid_d;
  logic       chg_q, chg_d;
  logic [3:0] last_q, last_d;
  logic       busy_q, busy_d;

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sl_q    <= 2'd0;
      cnt_q   <= 4'd0;
      stage_q <= 3'd0;
      word_q  <= 4'd0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      last_q  <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sl_q    <= sl_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; channels 0..2 shift into stage_q from the top so that
  // channel k ends up in bit k once channel 3 is appended as the MSB.
  always_comb begin
    state_d = state_q;
    sl_d    = sl_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    word_d  = word_q;
    valid_d = valid_q;
    chg_d   = chg_q;
    last_d  = last_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        sl_d  = 2'd0;
        cnt_d = 4'd0;
        if (START || CONT) begin
          state_d = ST_SCAN;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_SCAN: begin
        if (cnt_q == SETTLE_C) begin
          cnt_d = 4'd0;
          if (sl_q == 2'd3) begin
            word_d  = {MUX_OUT, stage_q};
            chg_d   = ({MUX_OUT, stage_q} != last_q);
            valid_d = 1'b1;
            sl_d    = 2'd0;
            state_d = ST_DONE;
          end else begin
            stage_d = {MUX_OUT, stage_q[2:1]};
            sl_d    = sl_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        sl_d = 2'd0;
        if (valid_q && READY) begin
          valid_d = 1'b0;
          last_d  = word_q;
          cnt_d   = 4'd0;
          if (CONT) begin
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sl_d    = 2'd0;
        cnt_d   = 4'd0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign SL    = sl_q;
  assign WORD  = word_q;
  assign VALID = valid_q;
  assign CHG   = chg_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Self-checking bench for mux_scan_sampler: scoreboard of expected words,
// plus cycle-exact checks of select stepping, latency and handshake.
module tb_mux_scan_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START, CONT, READY;
  logic [1:0] SL;
  logic [3:0] WORD;
  logic       VALID, CHG, BUSY;
  logic [3:0] mux_in;
  logic       MUX_OUT;

  logic       z_START, z_CONT, z_READY;
  logic [1:0] z_SL;
  logic [3:0] z_WORD;
  logic       z_VALID, z_CHG, z_BUSY;
  logic [3:0] z_mux_in;
  logic       z_MUX_OUT;

  assign MUX_OUT   = mux_in[SL];
  assign z_MUX_OUT = z_mux_in[z_SL];

  always #5 CLK = ~CLK;

  mux_scan_sampler #(.SETTLE(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CONT(CONT), .SL(SL),
    .MUX_OUT(MUX_OUT), .WORD(WORD), .VALID(VALID), .READY(READY),
    .CHG(CHG), .BUSY(BUSY)
  );

  mux_scan_sampler #(.SETTLE(0)) dut0 (
    .CLK(CLK), .RST(RST), .START(z_START), .CONT(z_CONT), .SL(z_SL),
    .MUX_OUT(z_MUX_OUT), .WORD(z_WORD), .VALID(z_VALID), .READY(z_READY),
    .CHG(z_CHG), .BUSY(z_BUSY)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] sb_q[$];
  logic [3:0] model_last = 4'd0;
  logic       valid_prev = 1'b0;
  logic [3:0] held_word  = 4'd0;
  logic       held_chg   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [3:0] w);
    sb_q.push_back({w, (w != model_last)});
    model_last = w;
  endtask

  // Compare every new word against the scoreboard and check it stays stable while pending
  task automatic monitor_step();
    logic [4:0] exp_v;
    if (VALID && !valid_prev) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_v = sb_q.pop_front();
        check_eq("word", 32'(WORD), 32'(exp_v[4:1]));
        check_eq("chg", 32'(CHG), 32'(exp_v[0]));
      end
      held_word = WORD;
      held_chg  = CHG;
    end else if (VALID) begin
      check_eq("word_hold", 32'(WORD), 32'(held_word));
      check_eq("chg_hold", 32'(CHG), 32'(held_chg));
    end
    valid_prev = VALID;
  endtask

  always @(negedge CLK) monitor_step();

  initial begin
    RST = 1'b1; START = 1'b0; CONT = 1'b0; READY = 1'b1; mux_in = 4'd0;
    z_START = 1'b0; z_CONT = 1'b0; z_READY = 1'b1; z_mux_in = 4'd0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_sl", 32'(SL), 32'd0);
    check_eq("rst_word", 32'(WORD), 32'd0);
    check_eq("rst_valid", 32'(VALID), 32'd0);
    check_eq("rst_chg", 32'(CHG), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);

    // Single shot, READY high
    mux_in = 4'b1010;
    expect_word(4'b1010);
    START = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      START = 1'b0;
      check_eq("t1_valid", 32'(VALID), 32'(k == 12));
      check_eq("t1_sl", 32'(SL), (k < 12) ? 32'(k / 3) : 32'd0);
      check_eq("t1_busy", 32'(BUSY), 32'(k < 13));
    end

    // Backpressure: READY low for 5 cycles after VALID rises
    READY = 1'b0;
    mux_in = 4'b0101;
    expect_word(4'b0101);
    START = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge CLK);
      START = 1'b0;
      check_eq("t2_valid", 32'(VALID), 32'(k >= 12 && k <= 16));
      check_eq("t2_busy", 32'(BUSY), 32'(k <= 16));
      if (k >= 12) check_eq("t2_sl", 32'(SL), 32'd0);
      if (k == 16) READY = 1'b1;
    end

    // Continuous mode, three words spaced 13 cycles apart
    mux_in = 4'b0110;
    expect_word(4'b0110);
    expect_word(4'b0110);
    expect_word(4'b0111);
    CONT = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (k == 25) mux_in = 4'b0111;
      if (k == 30) CONT = 1'b0;
      check_eq("t3_valid", 32'(VALID), 32'(k == 12 || k == 25 || k == 38));
      check_eq("t3_busy", 32'(BUSY), 32'(k < 39));
    end

    // START re-pulsed mid-scan is ignored
    mux_in = 4'b1100;
    expect_word(4'b1100);
    START = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      START = (k == 4);
      check_eq("t4_valid", 32'(VALID), 32'(k == 12));
      check_eq("t4_busy", 32'(BUSY), 32'(k < 13));
    end

    // Reset pulse while SL=2 discards the scan and clears last-accepted
    mux_in = 4'b1111;
    START = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      START = 1'b0;
    end
    check_eq("t5_sl_pre", 32'(SL), 32'd2);
    RST = 1'b1;
    #1;
    check_eq("t5_sl", 32'(SL), 32'd0);
    check_eq("t5_word", 32'(WORD), 32'd0);
    check_eq("t5_valid", 32'(VALID), 32'd0);
    check_eq("t5_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    model_last = 4'd0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      check_eq("t5_no_valid", 32'(VALID), 32'd0);
    end
    mux_in = 4'b0000;
    expect_word(4'b0000);
    START = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      START = 1'b0;
      check_eq("t5_rescan_valid", 32'(VALID), 32'(k == 12));
    end

    // SETTLE=0 instance: one cycle per channel, VALID 4 edges after START
    z_mux_in = 4'b1011;
    z_START = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      z_START = 1'b0;
      check_eq("t6_valid", 32'(z_VALID), 32'(k == 4));
      if (k < 4) check_eq("t6_sl", 32'(z_SL), 32'(k));
      if (k == 4) begin
        check_eq("t6_word", 32'(z_WORD), 32'd11);
        check_eq("t6_chg", 32'(z_CHG), 32'd1);
      end
      if (k == 5) check_eq("t6_busy", 32'(z_BUSY), 32'd0);
    end

    @(negedge CLK);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
